// File: rtl/cordic_vector.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cordic_vector
// Iterative CORDIC vectoring unit. Converts a signed Cartesian pair (X, Y) into
// a full-circle phase atan2(Y, X) (2^16 = 360 degrees) and a gain-compensated
// magnitude sqrt(X^2 + Y^2). One micro-rotation is performed per clock.
//
// Ports:
//   Clk_i    in   1  clock
//   RstN_i   in   1  asynchronous active-low reset
//   X_i      in  16  signed X component
//   Y_i      in  16  signed Y component
//   Start_i  in   1  conversion request, sampled only while idle
//   Angle_o  out 16  unsigned phase, held until the next completion
//   Mag_o    out 16  unsigned magnitude, held until the next completion
//   Done_o   out  1  one-cycle pulse, results valid in that cycle
//   Busy_o   out  1  high while a conversion is in progress
// -----------------------------------------------------------------------------
module cordic_vector #(
  parameter int Iterations = 16
) (
  input  logic               Clk_i,
  input  logic               RstN_i,
  input  logic signed [15:0] X_i,
  input  logic signed [15:0] Y_i,
  input  logic               Start_i,
  output logic        [15:0] Angle_o,
  output logic        [15:0] Mag_o,
  output logic               Done_o,
  output logic               Busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_ITER = 4'(Iterations - 1);

  state_e             state_q, state_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic        [15:0] angle_q, angle_d;
  logic        [15:0] mag_q, mag_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;

  // Datapath registers carry no reset: they are always loaded at acceptance
  // before being used, and the outputs are held in separate reset registers.
  logic signed [17:0] x_q, x_d;
  logic signed [17:0] y_q, y_d;
  logic        [15:0] z_q, z_d;

  logic signed [17:0] x_ext, y_ext;
  logic signed [17:0] x_sh, y_sh;

  // atan(2^-i) in the 16-bit full-circle phase format.
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  // Removes the CORDIC gain: (x * 0.60725 in Q1.15) >> 15, truncated and
  // clamped into the unsigned 16-bit output range.
  function automatic logic [15:0] scale_mag(input logic signed [17:0] x);
    logic signed [33:0] prod;
    logic signed [33:0] shifted;
    prod    = 34'(x) * 34'sd19898;
    shifted = prod >>> 15;
    if (shifted < 34'sd0)
      scale_mag = 16'd0;
    else if (shifted > 34'sd65535)
      scale_mag = 16'hFFFF;
    else
      scale_mag = shifted[15:0];
  endfunction

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      angle_q <= 16'd0;
      mag_q   <= 16'd0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  always_ff @(posedge Clk_i) begin
    x_q <= x_d;
    y_q <= y_d;
    z_q <= z_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_ext   = {{2{X_i[15]}}, X_i};
    y_ext   = {{2{Y_i[15]}}, Y_i};
    x_sh    = x_q >>> cnt_q;
    y_sh    = y_q >>> cnt_q;

    case (state_q)
      IDLE: begin
        if (Start_i) begin
          // Fold the left half-plane onto the right by a 180 degree rotation
          // so the micro-rotations only need to cover +-90 degrees.
          if (X_i[15]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = 16'h8000;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 16'h0000;
          end
          zero_d  = (X_i == 16'sd0) && (Y_i == 16'sd0);
          cnt_d   = 4'd0;
          state_d = ITER;
        end
      end

      ITER: begin
        // Rotate towards y = 0, accumulating the applied angle in z.
        if (!y_q[17]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(cnt_q);
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(cnt_q);
        end
        if (cnt_q == LAST_ITER) begin
          cnt_d   = 4'd0;
          state_d = SCALE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SCALE: begin
        // A zero vector has no defined phase; report 0/0 instead of the
        // arbitrary angle the iterations would accumulate.
        angle_d = zero_q ? 16'd0 : z_q;
        mag_d   = zero_q ? 16'd0 : scale_mag(x_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Angle_o = angle_q;
  assign Mag_o   = mag_q;
  assign Done_o  = done_q;
  assign Busy_o  = (state_q != IDLE);

endmodule
